// File: rtl/io_port_responder_if.sv
// io_port_responder_if
//   Processor load/store bus between a master (CPU or testbench) and the
//   memory-mapped IO port block.
//   MemWrite  - store strobe (master -> slave)
//   MemRead   - load strobe (master -> slave)
//   Address   - byte address (master -> slave)
//   WriteData - store data (master -> slave)
//   ReadData  - combinational load data (slave -> master)
//   Hit       - address falls inside the slave's 32-byte window (slave -> master)
interface io_port_responder_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (
    output MemWrite, MemRead, Address, WriteData,
    input  ReadData, Hit
  );

  modport slave (
    input  MemWrite, MemRead, Address, WriteData,
    output ReadData, Hit
  );
endinterface

// File: rtl/io_port_responder.sv
// io_port_responder
//   Memory-mapped IO port with an 8-bit synchronized input port, sticky
//   rising-edge flags, a 32-bit output port and a compare/match timer.
//   Register window (word offset = Address[4:2]):
//     0 OUT  1 IN  2 EDGE (W1C)  3 EDGE_IE  4 COUNT  5 CMP  6 CTRL  7 reserved
// Ports
//   clk     - single clock, rising edge
//   reset   - synchronous, active-high
//   bus     - processor load/store bus (slave side)
//   PortIn  - asynchronous external input pins
//   PortOut - registered output port (the OUT register)
//   IRQ     - level interrupt: enabled edge flags or enabled match flag
module io_port_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h1001_0100,  // must be 32-byte aligned
  parameter int          SYNC_STAGES  = 2               // legal range 2..3
) (
  input  logic                 clk,
  input  logic                 reset,
  io_port_responder_if.slave   bus,
  input  logic [7:0]           PortIn,
  output logic [31:0]          PortOut,
  output logic                 IRQ
);

  typedef enum logic [2:0] {
    REG_OUT     = 3'd0,
    REG_IN      = 3'd1,
    REG_EDGE    = 3'd2,
    REG_EDGE_IE = 3'd3,
    REG_COUNT   = 3'd4,
    REG_CMP     = 3'd5,
    REG_CTRL    = 3'd6,
    REG_RSVD    = 3'd7
  } reg_off_e;

  // Registers
  logic [31:0] r_out;
  logic [7:0]  r_edge;
  logic [7:0]  r_edge_ie;
  logic [31:0] r_count;
  logic [31:0] r_cmp;
  logic        r_ten;
  logic        r_mie;
  logic        r_mflag;

  logic [7:0]             r_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] r_sync_vld;
  logic [7:0]             r_in_dly;
  logic                   r_dly_vld;

  // Decode
  logic       w_hit;
  reg_off_e   w_off;
  logic       w_wr;
  logic       w_wr_out, w_wr_edge, w_wr_ie, w_wr_cmp, w_wr_ctrl;
  logic [7:0] w_in;
  logic [7:0] w_rise;
  logic [7:0] w_edge_clr;
  logic       w_mflag_clr;
  logic       w_match;
  logic       w_unused_addr;

  assign w_hit         = (bus.Address[31:5] == BASE_ADDRESS[31:5]);
  assign w_off         = reg_off_e'(bus.Address[4:2]);
  assign w_unused_addr = ^bus.Address[1:0];  // byte lanes ignored: word accesses only

  assign w_wr      = bus.MemWrite & w_hit;
  assign w_wr_out  = w_wr && (w_off == REG_OUT);
  assign w_wr_edge = w_wr && (w_off == REG_EDGE);
  assign w_wr_ie   = w_wr && (w_off == REG_EDGE_IE);
  assign w_wr_cmp  = w_wr && (w_off == REG_CMP);
  assign w_wr_ctrl = w_wr && (w_off == REG_CTRL);

  assign w_edge_clr  = w_wr_edge ? bus.WriteData[7:0] : 8'h00;
  assign w_mflag_clr = w_wr_ctrl & bus.WriteData[2];

  // ---------------------------------------------------------------------------
  // PortIn synchronizer and edge detector.
  // A valid bit travels alongside the data so that the first real sample after
  // reset is never compared against the cleared flops: pins that are already
  // high when reset releases produce no edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 8'h00;
      r_sync_vld <= '0;
      r_in_dly   <= 8'h00;
      r_dly_vld  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this loop into a shift chain.
      r_sync[0] <= PortIn;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
      r_in_dly   <= r_sync[SYNC_STAGES-1];
      r_dly_vld  <= r_sync_vld[SYNC_STAGES-1];
    end
  end

  assign w_in   = r_sync[SYNC_STAGES-1];
  assign w_rise = r_dly_vld ? (w_in & ~r_in_dly) : 8'h00;

  // ---------------------------------------------------------------------------
  // Timer: counts while enabled; on COUNT==CMP it reloads 0 and flags a match.
  // A CMP below the current COUNT simply lets COUNT run through the 32-bit wrap.
  // ---------------------------------------------------------------------------
  assign w_match = r_ten && (r_count == r_cmp);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 32'h0;
      r_mflag <= 1'b0;
    end else begin
      if (r_ten) r_count <= w_match ? 32'h0 : r_count + 32'd1;
      // Hardware set wins over a same-cycle W1C clear.
      r_mflag <= w_match | (r_mflag & ~w_mflag_clr);
    end
  end

  // ---------------------------------------------------------------------------
  // Software-visible registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out     <= 32'h0;
      r_edge    <= 8'h00;
      r_edge_ie <= 8'h00;
      r_cmp     <= 32'h0;
      r_ten     <= 1'b0;
      r_mie     <= 1'b0;
    end else begin
      // Hardware edge set wins over a same-cycle W1C clear.
      r_edge <= (r_edge & ~w_edge_clr) | w_rise;
      if (w_wr_out) r_out     <= bus.WriteData;
      if (w_wr_ie)  r_edge_ie <= bus.WriteData[7:0];
      if (w_wr_cmp) r_cmp     <= bus.WriteData;
      if (w_wr_ctrl) begin
        r_ten <= bus.WriteData[0];
        r_mie <= bus.WriteData[1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Zero-latency read mux; a same-cycle write is seen only from the next cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assigning the default first means every path drives ReadData,
    // so no latch is inferred.
    bus.ReadData = 32'h0;
    if (bus.MemRead && w_hit) begin
      case (w_off)
        REG_OUT:     bus.ReadData = r_out;
        REG_IN:      bus.ReadData = {24'h0, w_in};
        REG_EDGE:    bus.ReadData = {24'h0, r_edge};
        REG_EDGE_IE: bus.ReadData = {24'h0, r_edge_ie};
        REG_COUNT:   bus.ReadData = r_count;
        REG_CMP:     bus.ReadData = r_cmp;
        REG_CTRL:    bus.ReadData = {29'h0, r_mflag, r_mie, r_ten};
        default:     bus.ReadData = 32'h0;
      endcase
    end
  end

  assign bus.Hit = w_hit;
  assign PortOut = r_out;
  assign IRQ     = (|(r_edge & r_edge_ie)) | (r_mflag & r_mie);

endmodule
